// File: rtl/jtag_shift_ctrl_pkg.sv
// Shared types and sizing for the JTAG shift controller.
package jtag_shift_pkg;

    localparam int unsigned MAX_BITS     = 32;
    localparam int unsigned TRST_PERIODS = 8;
    localparam int unsigned IDX_W        = $clog2(MAX_BITS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TRST     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        RESP     = 3'd4
    } state_t;

endpackage

// File: rtl/jtag_shift_ctrl_if.sv
// Command/response handshake bundle between a host and jtag_shift_ctrl.
interface jtag_shift_ctrl_if;
    import jtag_shift_pkg::*;

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [IDX_W-1:0]    cmd_len_i;
    logic [MAX_BITS-1:0] cmd_tms_i;
    logic [MAX_BITS-1:0] cmd_tdi_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [MAX_BITS-1:0] rsp_tdo_o;
    logic                trst_req_i;

    modport master (
        output cmd_valid_i, cmd_len_i, cmd_tms_i, cmd_tdi_i, rsp_ready_i, trst_req_i,
        input  cmd_ready_o, rsp_valid_o, rsp_tdo_o
    );

    modport slave (
        input  cmd_valid_i, cmd_len_i, cmd_tms_i, cmd_tdi_i, rsp_ready_i, trst_req_i,
        output cmd_ready_o, rsp_valid_o, rsp_tdo_o
    );

endinterface

// File: rtl/jtag_shift_ctrl_tck_div.sv
// TCK half-period timer: down-counter reloaded by the FSM, expires at terminal count 0.
module jtag_tck_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic expire_o
);

    localparam logic [7:0] LOAD_VAL = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign expire_o = (cnt_q == 8'd0);

endmodule

// File: rtl/jtag_shift_ctrl.sv
// JTAG shift engine: clocks up to 32 TMS/TDI bits out, captures TDO, and issues TAP reset pulses.
//
// state    | meaning
// IDLE     | ready for a command or a TAP reset request
// TRST     | trstn_o held low for TRST_PERIODS half-periods
// SHIFT_LO | TCK low, current TMS/TDI bit on the pins
// SHIFT_HI | TCK high, TDO for the current bit already captured
// RESP     | captured TDO offered until the host takes it
module jtag_shift_ctrl
    import jtag_shift_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    jtag_shift_ctrl_if.slave bus,
    output logic             tck_o,
    output logic             tms_o,
    output logic             tdi_o,
    output logic             trstn_o,
    input  logic             tdo_i
);

    state_t              state_q, state_d;
    logic [MAX_BITS-1:0] tms_q, tdi_q, tdo_q;
    logic [IDX_W-1:0]    len_q, idx_q, idx_nxt;
    logic [2:0]          trst_cnt_q;
    logic                tck_q, tms_out_q, tdi_out_q, trstn_q, rsp_valid_q;
    logic                div_load, div_expire, cmd_ready, accept;

    jtag_tck_div #(.CLK_DIV(CLK_DIV)) u_tck_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (div_load),
        .expire_o (div_expire)
    );

    assign cmd_ready = (state_q == IDLE) && !bus.trst_req_i;
    assign accept    = cmd_ready && bus.cmd_valid_i;
    assign idx_nxt   = idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        div_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.trst_req_i) begin
                    state_d  = TRST;
                    div_load = 1'b1;
                end else if (bus.cmd_valid_i) begin
                    state_d  = SHIFT_LO;
                    div_load = 1'b1;
                end
            end
            TRST: begin
                if (div_expire) begin
                    div_load = 1'b1;
                    if (trst_cnt_q == 3'd0) state_d = IDLE;
                end
            end
            SHIFT_LO: begin
                if (div_expire) begin
                    div_load = 1'b1;
                    state_d  = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (div_expire) begin
                    div_load = 1'b1;
                    state_d  = (idx_q == len_q) ? RESP : SHIFT_LO;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin levels are registered from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tms_q       <= '0;
            tdi_q       <= '0;
            tdo_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            trst_cnt_q  <= '0;
            tck_q       <= 1'b0;
            tms_out_q   <= 1'b0;
            tdi_out_q   <= 1'b0;
            trstn_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tck_q       <= (state_d == SHIFT_HI);
            trstn_q     <= (state_d != TRST);
            rsp_valid_q <= (state_d == RESP);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tms_q     <= bus.cmd_tms_i;
                        tdi_q     <= bus.cmd_tdi_i;
                        len_q     <= bus.cmd_len_i;
                        idx_q     <= '0;
                        tdo_q     <= '0;
                        tms_out_q <= bus.cmd_tms_i[0];
                        tdi_out_q <= bus.cmd_tdi_i[0];
                    end else if (bus.trst_req_i) begin
                        trst_cnt_q <= 3'(TRST_PERIODS - 1);
                    end
                end
                TRST: begin
                    if (div_expire && trst_cnt_q != 3'd0) trst_cnt_q <= trst_cnt_q - 3'd1;
                end
                SHIFT_LO: begin
                    if (div_expire) tdo_q[idx_q] <= tdo_i;
                end
                SHIFT_HI: begin
                    if (div_expire && idx_q != len_q) begin
                        idx_q     <= idx_nxt;
                        tms_out_q <= tms_q[idx_nxt];
                        tdi_out_q <= tdi_q[idx_nxt];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_tdo_o   = tdo_q;
    assign tck_o           = tck_q;
    assign tms_o           = tms_out_q;
    assign tdi_o           = tdi_out_q;
    assign trstn_o         = trstn_q;

endmodule

// File: tb/tb_jtag_shift_ctrl.sv
// Directed bench for jtag_shift_ctrl at CLK_DIV = 4, 1 and 2 (one instance each).
module tb_jtag_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cmd_valid, rsp_ready, trst_req;
    logic [2:0]  cmd_ready, rsp_valid, tck, tms, tdi, trstn, tdo;
    logic [4:0]  cmd_len [3];
    logic [31:0] cmd_tms [3];
    logic [31:0] cmd_tdi [3];
    logic [31:0] rsp_tdo [3];
    logic [1:0]  tdo_mode [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned DIV = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
        jtag_shift_ctrl_if bus ();
        assign bus.cmd_valid_i = cmd_valid[g];
        assign bus.cmd_len_i   = cmd_len[g];
        assign bus.cmd_tms_i   = cmd_tms[g];
        assign bus.cmd_tdi_i   = cmd_tdi[g];
        assign bus.rsp_ready_i = rsp_ready[g];
        assign bus.trst_req_i  = trst_req[g];
        assign cmd_ready[g]    = bus.cmd_ready_o;
        assign rsp_valid[g]    = bus.rsp_valid_o;
        assign rsp_tdo[g]      = bus.rsp_tdo_o;
        // tdo source: 0 = loop from tdi_o, 1 = tied high, 2 = tied low, 3 = loop from tms_o
        assign tdo[g] = (tdo_mode[g] == 2'd0) ? tdi[g] :
                        (tdo_mode[g] == 2'd1) ? 1'b1 :
                        (tdo_mode[g] == 2'd2) ? 1'b0 : tms[g];
        jtag_shift_ctrl #(.CLK_DIV(DIV)) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .bus     (bus),
            .tck_o   (tck[g]),
            .tms_o   (tms[g]),
            .tdi_o   (tdi[g]),
            .trstn_o (trstn[g]),
            .tdo_i   (tdo[g])
        );
    end

    // Pin monitor: TCK rising edges, TCK-high cycles, and TMS/TDI movement while TCK is high.
    int         rises [3] = '{0, 0, 0};
    int         his   [3] = '{0, 0, 0};
    int         viol = 0;
    logic [2:0] p_tck = '0, p_tms = '0, p_tdi = '0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst_n) begin
                if (tck[i] && !p_tck[i]) rises[i] <= rises[i] + 1;
                if (tck[i]) his[i] <= his[i] + 1;
                if (tck[i] && (tms[i] != p_tms[i] || tdi[i] != p_tdi[i])) viol <= viol + 1;
            end
            p_tck[i] <= tck[i];
            p_tms[i] <= tms[i];
            p_tdi[i] <= tdi[i];
        end
    end

    typedef struct {
        int          sel;
        logic [4:0]  len;
        logic [31:0] tms_v;
        logic [31:0] tdi_v;
        logic [1:0]  mode;
        logic [31:0] exp_tdo;
        int          exp_lat;
        int          exp_rise;
        int          exp_hi;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Starts at the negedge where the command is seen accepted; waits for the response.
    task automatic finish_cmd(input int sel, output logic [31:0] tdo_v, output int lat,
                              output int nrise, output int nhi);
        int r0, h0;
        r0 = rises[sel];
        h0 = his[sel];
        @(negedge clk);
        cmd_valid[sel] = 1'b0;
        cmd_len[sel]   = ~cmd_len[sel];
        cmd_tms[sel]   = ~cmd_tms[sel];
        cmd_tdi[sel]   = ~cmd_tdi[sel];
        lat = 0;
        while (!rsp_valid[sel] && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        tdo_v = rsp_tdo[sel];
        nrise = rises[sel] - r0;
        nhi   = his[sel] - h0;
    endtask

    task automatic start_cmd(input vec_t v);
        int n;
        @(negedge clk);
        tdo_mode[v.sel]  = v.mode;
        cmd_len[v.sel]   = v.len;
        cmd_tms[v.sel]   = v.tms_v;
        cmd_tdi[v.sel]   = v.tdi_v;
        cmd_valid[v.sel] = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready[v.sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(cmd_ready[v.sel]), 32'd1);
    endtask

    task automatic release_rsp(input int sel);
        rsp_ready[sel] = 1'b1;
        @(negedge clk);
        rsp_ready[sel] = 1'b0;
        check("idle_after_rsp", 32'({rsp_valid[sel], cmd_ready[sel]}), 32'b01);
    endtask

    initial begin
        logic [31:0] got;
        int          lat, nr, nh, low, n, r0;
        logic        flag;
        vec_t        v;

        cmd_valid = '0; rsp_ready = '0; trst_req = '0;
        for (int i = 0; i < 3; i++) begin
            cmd_len[i] = '0; cmd_tms[i] = '0; cmd_tdi[i] = '0; tdo_mode[i] = 2'd0;
        end

        vecs[0] = '{0,  5'd7, 32'h0000_0000, 32'h0000_00A5, 2'd0, 32'h0000_00A5,  64,  8,  32};
        vecs[1] = '{1, 5'd31, 32'h1234_5678, 32'hDEAD_BEEF, 2'd1, 32'hFFFF_FFFF,  64, 32,  32};
        vecs[2] = '{2,  5'd0, 32'h0000_0000, 32'h0000_0001, 2'd0, 32'h0000_0001,   4,  1,   2};
        vecs[3] = '{2,  5'd4, 32'h0000_0000, 32'hFFFF_FFF5, 2'd0, 32'h0000_0015,  20,  5,  10};
        vecs[4] = '{0, 5'd15, 32'h0000_FFFF, 32'h0000_FFFF, 2'd2, 32'h0000_0000, 128, 16,  64};
        vecs[5] = '{1, 5'd31, 32'h0000_0000, 32'h8000_0001, 2'd0, 32'h8000_0001,  64, 32,  32};
        vecs[6] = '{2,  5'd7, 32'h0000_003C, 32'h0000_0000, 2'd3, 32'h0000_003C,  32,  8,  16};
        vecs[7] = '{0, 5'd31, 32'h0000_0000, 32'hC0FF_EE11, 2'd0, 32'hC0FF_EE11, 256, 32, 128};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_pins[%0d]", i),
                  32'({tck[i], tms[i], tdi[i], trstn[i], rsp_valid[i], cmd_ready[i]}), 32'b000101);
        for (int i = 0; i < 3; i++) check($sformatf("reset_tdo[%0d]", i), rsp_tdo[i], 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            start_cmd(vecs[k]);
            finish_cmd(vecs[k].sel, got, lat, nr, nh);
            check($sformatf("v%0d_tdo", k), got, vecs[k].exp_tdo);
            check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            check($sformatf("v%0d_tck_rises", k), 32'(nr), 32'(vecs[k].exp_rise));
            check($sformatf("v%0d_tck_high_cycles", k), 32'(nh), 32'(vecs[k].exp_hi));
            release_rsp(vecs[k].sel);
        end

        // TAP reset request and command arriving together at CLK_DIV=2.
        @(negedge clk);
        tdo_mode[2] = 2'd0; cmd_len[2] = 5'd1; cmd_tms[2] = 32'd0; cmd_tdi[2] = 32'd2;
        cmd_valid[2] = 1'b1; trst_req[2] = 1'b1;
        #1;
        check("ready_with_trst_req", 32'(cmd_ready[2]), 32'd0);
        @(negedge clk);
        trst_req[2] = 1'b0;
        low = 0; flag = 1'b0;
        while (trstn[2] == 1'b0 && low < 100) begin
            if (cmd_ready[2]) flag = 1'b1;
            low++;
            @(negedge clk);
        end
        check("trst_low_cycles", 32'(low), 32'd16);
        check("ready_during_trst", 32'(flag), 32'd0);
        check("ready_after_trst", 32'(cmd_ready[2]), 32'd1);
        finish_cmd(2, got, lat, nr, nh);
        check("post_trst_tdo", got, 32'd2);
        check("post_trst_latency", 32'(lat), 32'd8);
        release_rsp(2);

        // Response back-pressure, with a TAP reset request that must be dropped.
        v = '{0, 5'd3, 32'h0, 32'h9, 2'd0, 32'h9, 32, 4, 16};
        start_cmd(v);
        finish_cmd(0, got, lat, nr, nh);
        check("bp_tdo", got, 32'h9);
        check("bp_latency", 32'(lat), 32'd32);
        r0 = rises[0]; flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            trst_req[0] = (i == 3);
            @(negedge clk);
            if (!rsp_valid[0] || rsp_tdo[0] != 32'h9 || cmd_ready[0]) flag = 1'b0;
        end
        trst_req[0] = 1'b0;
        check("bp_resp_held", 32'(flag), 32'd1);
        check("bp_no_tck", 32'(rises[0] - r0), 32'd0);
        release_rsp(0);
        flag = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!trstn[0] || !cmd_ready[0]) flag = 1'b0;
        end
        check("trst_not_queued", 32'(flag), 32'd1);

        // Reset during the third TCK high phase.
        v = '{0, 5'd7, 32'h0, 32'hFF, 2'd0, 32'hFF, 64, 8, 32};
        start_cmd(v);
        r0 = rises[0];
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        n = 0;
        while (rises[0] - r0 < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("third_tck_high", 32'(tck[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midshift_reset_pins", 32'({tck[0], tms[0], tdi[0], trstn[0], rsp_valid[0]}), 32'b00010);
        check("midshift_reset_tdo", rsp_tdo[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid[0]) flag = 1'b1;
        end
        check("no_rsp_after_abort", 32'(flag), 32'd0);
        v = '{0, 5'd7, 32'h0, 32'h5A, 2'd0, 32'h5A, 64, 8, 32};
        start_cmd(v);
        finish_cmd(0, got, lat, nr, nh);
        check("fresh_tdo", got, 32'h5A);
        check("fresh_latency", 32'(lat), 32'd64);
        check("fresh_tck_rises", 32'(nr), 32'd8);
        release_rsp(0);

        @(negedge clk);
        check("tms_tdi_stable_tck_high", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_shift_ctrl.md
JTAG_SHIFT_CTRL -- requirements
Module: jtag_shift_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving the TCK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have port clk  in  1  system clock; the only clock.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid_i  in  1  shift command valid.
REQ-005 SHALL have port cmd_ready_o  out  1  command accepted when valid & ready.
REQ-006 SHALL have port cmd_len_i  in  5  bit count minus one (0 = 1 bit, 31 = 32 bits).
REQ-007 SHALL have port cmd_tms_i  in  32  TMS bits; bit 0 is shifted first.
REQ-008 SHALL have port cmd_tdi_i  in  32  TDI bits; bit 0 is shifted first.
REQ-009 SHALL have port rsp_valid_o  out  1  captured TDO valid.
REQ-010 SHALL have port rsp_ready_i  in  1  response consumed when valid & ready.
REQ-011 SHALL have port rsp_tdo_o  out  32  captured TDO; first bit at [0].
REQ-012 SHALL have port trst_req_i  in  1  single-cycle request for a TAP reset pulse.
REQ-013 SHALL have ports tck_o, tms_o, tdi_o, trstn_o (out, 1 each) and tdo_i (in, 1), forming the JTAG pins.

Function
REQ-014 SHALL implement states IDLE, TRST, SHIFT_LO, SHIFT_HI, RESP.
REQ-015 IDLE: cmd_ready_o=1 only here and only while trst_req_i=0; every other state drives cmd_ready_o=0.
REQ-016 IDLE + trst_req_i=1 SHALL go to TRST, taking priority over a simultaneous cmd_valid_i.
REQ-017 TRST SHALL hold trstn_o=0 and tck_o=0 for exactly 8*CLK_DIV clk cycles, then return to IDLE with trstn_o=1.
REQ-018 On command accept, the block SHALL latch tms/tdi/len, clear the TDO shift register and bit counter, and enter SHIFT_LO.
REQ-019 SHIFT_LO SHALL drive tck_o=0 with tms_o/tdi_o set to the current bit, hold for CLK_DIV cycles, then enter SHIFT_HI.
REQ-020 On the SHIFT_LO->SHIFT_HI edge, tck_o SHALL go to 1 and tdo_i SHALL be sampled into rsp_tdo_o[bit index].
REQ-021 SHIFT_HI SHALL hold for CLK_DIV cycles; if bit index == len, go to RESP; otherwise increment the index and go to SHIFT_LO.
REQ-022 tms_o and tdi_o SHALL change only on the SHIFT_HI->SHIFT_LO (TCK falling) edge, and SHALL keep their last value in IDLE, TRST and RESP.
REQ-023 Accept-to-rsp_valid_o latency SHALL be exactly (len+1)*2*CLK_DIV clk cycles.
REQ-024 RESP SHALL hold rsp_valid_o=1 and rsp_tdo_o stable until rsp_ready_i=1, then return to IDLE on the next cycle.
REQ-025 Bits above len in rsp_tdo_o SHALL read 0.
REQ-026 trst_req_i outside IDLE SHALL be ignored, not queued.
REQ-027 The bit index SHALL be 5 bits and SHALL never wrap; len=31 ends after index 31.
REQ-028 Inputs cmd_* SHALL NOT be sampled after accept; changes mid-shift have no effect.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, tck_o=0, tms_o=0, tdi_o=0, trstn_o=1, rsp_valid_o=0, rsp_tdo_o=0, and all counters to 0.
REQ-030 Reset asserted mid-shift or mid-TRST SHALL abort the operation with no response produced.

Structure
REQ-031 Package jtag_shift_pkg SHALL hold the state enum, MAX_BITS=32, and TRST_PERIODS=8.
REQ-032 The half-period counter SHALL be the sub-module jtag_tck_div: 8-bit counter, load/expire handshake with the FSM.
REQ-033 Everything else SHALL be a single FSM plus shift registers in jtag_shift_ctrl.

Verification
REQ-034 CLK_DIV=4, len=7, tms=0x00, tdi=0xA5, tdo_i looped to tdi_o -> rsp_tdo_o=0x000000A5, rsp_valid_o 64 cycles after accept, 8 TCK rising edges.
REQ-035 CLK_DIV=1, len=31, tdi=0xDEADBEEF, tdo_i tied 1 -> rsp_tdo_o=0xFFFFFFFF after 64 cycles; tck_o toggles every cycle.
REQ-036 trst_req_i and cmd_valid_i both asserted in IDLE, CLK_DIV=2 -> trstn_o low for 16 cycles, cmd_ready_o=0 throughout; command accepted afterwards.
REQ-037 rsp_ready_i held 0 for 10 cycles after rsp_valid_o -> rsp_tdo_o stable, cmd_ready_o=0, no TCK edges; IDLE one cycle after the handshake.
REQ-038 rst_n pulsed low at the 3rd TCK high phase -> outputs at reset values immediately, no rsp_valid_o; a fresh command then completes correctly.
REQ-039 A checker SHALL confirm tms_o/tdi_o never change while tck_o=1 or on its rising edge.
